// File: rtl/al422_frame_writer_if.sv
`default_nettype none
// ============================================================================
// al422_frame_writer_if : pixel stream handshake into the AL422 frame writer
// Rev 1.0
// ============================================================================
interface al422_frame_writer_if;
  logic        frame_start;
  logic        pix_valid;
  logic [14:0] pix_data;
  logic        pix_ready;

  modport master (
    output frame_start,
    output pix_valid,
    output pix_data,
    input  pix_ready
  );

  modport slave (
    input  frame_start,
    input  pix_valid,
    input  pix_data,
    output pix_ready
  );
endinterface
`default_nettype wire

// File: rtl/al422_frame_writer.sv
`default_nettype none
// ============================================================================
// al422_frame_writer : serialises RGB555 pixels into AL422 FIFO bytes, low
// byte first. Optional test-pattern source: AL422_WRITER_TEST_PATTERN_EN.
// Rev 1.0
// ============================================================================
module al422_frame_writer #(
  parameter int FRAME_PIXELS = 2048,
  parameter int WRST_CYCLES  = 4
) (
  input  wire logic           in_clk_i,
  input  wire logic           in_rst_i,
`ifdef AL422_WRITER_TEST_PATTERN_EN
  input  wire logic           test_mode_i,
`endif
  al422_frame_writer_if.slave pix_if,
  output logic                fifo_wrst_n_o,
  output logic                fifo_we_n_o,
  output logic [7:0]          fifo_data_o,
  output logic                frame_done_o,
  output logic                frame_err_o,
  output logic                busy_o
);

  localparam logic [15:0] LAST_PIX  = 16'(FRAME_PIXELS - 1);
  localparam logic [7:0]  LAST_WRST = 8'(WRST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WRST = 3'd1,
    S_LOW  = 3'd2,
    S_HIGH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  wrst_cnt_q;
  logic [15:0] pix_cnt_q;
  logic [7:0]  hi_byte_q;
  logic        wrst_n_q;
  logic        we_n_q;
  logic [7:0]  data_q;
  logic        frame_done_q;
  logic        frame_err_q;

  logic [15:0] pix_word;
  logic        handshake;

`ifdef AL422_WRITER_TEST_PATTERN_EN
  logic        test_mode_q;
  logic [2:0]  bar_idx;
  logic [15:0] bar_word;

  // Colour bar changes every 8 pixels: bit0 red, bit1 green, bit2 blue.
  assign bar_idx  = pix_cnt_q[5:3];
  assign bar_word = {1'b0, {5{bar_idx[2]}}, {5{bar_idx[1]}}, {5{bar_idx[0]}}};
  assign pix_word = test_mode_q ? bar_word : {1'b0, pix_if.pix_data};
`else
  assign pix_word = {1'b0, pix_if.pix_data};
`endif

  // frame_start takes priority over any pixel offered in the same cycle.
  assign pix_if.pix_ready = (state_q == S_LOW) && !pix_if.frame_start;
  assign handshake        = pix_if.pix_valid && pix_if.pix_ready;

  always_ff @(posedge in_clk_i or posedge in_rst_i) begin
    if (in_rst_i) begin
      state_q      <= S_IDLE;
      wrst_cnt_q   <= 8'd0;
      pix_cnt_q    <= 16'd0;
      hi_byte_q    <= 8'd0;
      wrst_n_q     <= 1'b1;
      we_n_q       <= 1'b1;
      data_q       <= 8'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef AL422_WRITER_TEST_PATTERN_EN
      test_mode_q  <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (pix_if.frame_start) begin
        state_q    <= S_WRST;
        wrst_cnt_q <= 8'd0;
        pix_cnt_q  <= 16'd0;
        wrst_n_q   <= 1'b0;
        we_n_q     <= 1'b1;
        // A frame already complete in DONE still reports completion.
        if (state_q == S_LOW || state_q == S_HIGH) begin
          frame_err_q <= 1'b1;
        end
        if (state_q == S_DONE) begin
          frame_done_q <= 1'b1;
        end
`ifdef AL422_WRITER_TEST_PATTERN_EN
        test_mode_q <= test_mode_i;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            we_n_q   <= 1'b1;
            wrst_n_q <= 1'b1;
          end
          S_WRST: begin
            if (wrst_cnt_q == LAST_WRST) begin
              state_q  <= S_LOW;
              wrst_n_q <= 1'b1;
            end else begin
              wrst_cnt_q <= wrst_cnt_q + 8'd1;
            end
          end
          S_LOW: begin
            if (handshake) begin
              data_q    <= pix_word[7:0];
              hi_byte_q <= pix_word[15:8];
              we_n_q    <= 1'b0;
              state_q   <= S_HIGH;
            end else begin
              we_n_q <= 1'b1;
            end
          end
          S_HIGH: begin
            data_q    <= hi_byte_q;
            we_n_q    <= 1'b0;
            pix_cnt_q <= pix_cnt_q + 16'd1;
            state_q   <= (pix_cnt_q == LAST_PIX) ? S_DONE : S_LOW;
          end
          S_DONE: begin
            we_n_q       <= 1'b1;
            frame_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            we_n_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign fifo_wrst_n_o = wrst_n_q;
  assign fifo_we_n_o   = we_n_q;
  assign fifo_data_o   = data_q;
  assign frame_done_o  = frame_done_q;
  assign frame_err_o   = frame_err_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_al422_frame_writer.sv
`default_nettype none
// ============================================================================
// tb_al422_frame_writer : directed vector table plus restart/reset sequences
// Rev 1.0
// ============================================================================
module tb_al422_frame_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  al422_frame_writer_if pif();
  logic       wrst_n, we_n, done, err, busy;
  logic [7:0] fdata;

  al422_frame_writer #(.FRAME_PIXELS(4), .WRST_CYCLES(4)) dut (
    .in_clk_i      (clk),
    .in_rst_i      (rst),
`ifdef AL422_WRITER_TEST_PATTERN_EN
    .test_mode_i   (1'b0),
`endif
    .pix_if        (pif),
    .fifo_wrst_n_o (wrst_n),
    .fifo_we_n_o   (we_n),
    .fifo_data_o   (fdata),
    .frame_done_o  (done),
    .frame_err_o   (err),
    .busy_o        (busy)
  );

`ifdef AL422_WRITER_TEST_PATTERN_EN
  al422_frame_writer_if tpif();
  logic       tp_wrst_n, tp_we_n, tp_done, tp_err, tp_busy;
  logic [7:0] tp_data;

  al422_frame_writer #(.FRAME_PIXELS(16), .WRST_CYCLES(4)) tp_dut (
    .in_clk_i      (clk),
    .in_rst_i      (rst),
    .test_mode_i   (1'b1),
    .pix_if        (tpif),
    .fifo_wrst_n_o (tp_wrst_n),
    .fifo_we_n_o   (tp_we_n),
    .fifo_data_o   (tp_data),
    .frame_done_o  (tp_done),
    .frame_err_o   (tp_err),
    .busy_o        (tp_busy)
  );
`endif

  typedef struct {
    logic        fs;
    logic        v;
    logic [14:0] d;
    logic        e_wrst_n;
    logic        e_we_n;
    logic [7:0]  e_data;
    logic        e_done;
    logic        e_busy;
    logic        e_ready;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic fs, input logic v, input logic [14:0] d,
                              input logic wr, input logic we, input logic [7:0] dt,
                              input logic dn, input logic bs, input logic rd);
    vec_t r;
    r.fs = fs; r.v = v; r.d = d;
    r.e_wrst_n = wr; r.e_we_n = we; r.e_data = dt;
    r.e_done = dn; r.e_busy = bs; r.e_ready = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with fifo_wrst_n low, starting with the current one.
  task automatic wait_wrst(output int n);
    n = 0;
    while (wrst_n === 1'b0 && n < 20) begin
      n++;
      tick();
    end
  endtask

  // Counts write-enable cycles until frame_done is seen.
  task automatic wait_done(input string nm, output int n);
    int cyc;
    n   = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (we_n === 1'b0) n++;
      tick();
      cyc++;
    end
    chk({nm, "_done_seen"}, {15'd0, done}, 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    pif.frame_start = 1'b0;
    pif.pix_valid   = 1'b0;
    pif.pix_data    = 15'd0;
`ifdef AL422_WRITER_TEST_PATTERN_EN
    tpif.frame_start = 1'b0;
    tpif.pix_valid   = 1'b0;
    tpif.pix_data    = 15'd0;
`endif

    //                 fs v  d         wr we data  dn bs rd
    tbl.push_back(mk(1, 0, 15'h0000, 1, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 15'h7FFF, 0, 1, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h7FFF, 0, 1, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h7FFF, 0, 1, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h7FFF, 0, 1, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h7FFF, 1, 1, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h1234, 1, 0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h1234, 1, 0, 8'h7F, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h0001, 1, 0, 8'h34, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h0001, 1, 0, 8'h12, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h4210, 1, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h4210, 1, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h4210, 1, 0, 8'h10, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h4210, 1, 0, 8'h42, 0, 1, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 8'h42, 1, 0, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 8'h42, 0, 0, 0));
    // second frame: pix_valid high two cycles, low two cycles
    tbl.push_back(mk(1, 0, 15'h0000, 1, 1, 8'h42, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 0, 1, 8'h42, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h0000, 0, 1, 8'h42, 0, 1, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 0, 1, 8'h42, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h0000, 0, 1, 8'h42, 0, 1, 0));
    tbl.push_back(mk(0, 1, 15'h7FFF, 1, 1, 8'h42, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h7FFF, 1, 0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 8'h7F, 0, 1, 1));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 8'h7F, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h1234, 1, 1, 8'h7F, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h1234, 1, 0, 8'h34, 0, 1, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 8'h12, 0, 1, 1));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 8'h12, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h0001, 1, 1, 8'h12, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h0001, 1, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h4210, 1, 1, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 1, 15'h4210, 1, 0, 8'h10, 0, 1, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 0, 8'h42, 0, 1, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 8'h42, 1, 0, 0));
    tbl.push_back(mk(0, 0, 15'h0000, 1, 1, 8'h42, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_err", {15'd0, err}, 16'd0);

    foreach (tbl[i]) begin
      chk($sformatf("row%0d wrst_n", i), {15'd0, wrst_n}, {15'd0, tbl[i].e_wrst_n});
      chk($sformatf("row%0d we_n", i),   {15'd0, we_n},   {15'd0, tbl[i].e_we_n});
      chk($sformatf("row%0d data", i),   {8'd0, fdata},   {8'd0, tbl[i].e_data});
      chk($sformatf("row%0d done", i),   {15'd0, done},   {15'd0, tbl[i].e_done});
      chk($sformatf("row%0d busy", i),   {15'd0, busy},   {15'd0, tbl[i].e_busy});
      pif.frame_start = tbl[i].fs;
      pif.pix_valid   = tbl[i].v;
      pif.pix_data    = tbl[i].d;
      #1;
      chk($sformatf("row%0d ready", i), {15'd0, pif.pix_ready}, {15'd0, tbl[i].e_ready});
      tick();
    end
    chk("table_err", {15'd0, err}, 16'd0);

    // frame_start together with a valid pixel in LOW
    pif.frame_start = 1'b1; pif.pix_valid = 1'b0;
    tick();
    pif.frame_start = 1'b0;
    wait_wrst(n);
    chk("B_wrst_len", 16'(n), 16'd4);
    chk("B_err_before", {15'd0, err}, 16'd0);
    pif.pix_valid = 1'b1; pif.pix_data = 15'h1234; pif.frame_start = 1'b1;
    #1;
    chk("B_ready_blocked", {15'd0, pif.pix_ready}, 16'd0);
    tick();
    chk("B_no_write", {15'd0, we_n}, 16'd1);
    chk("B_wrst_entered", {15'd0, wrst_n}, 16'd0);
    chk("B_err_set", {15'd0, err}, 16'd1);
    pif.frame_start = 1'b0;
    wait_wrst(n);
    chk("B_wrst_len2", 16'(n), 16'd4);
    tick();
    chk("B_pixel_kept_data", {8'd0, fdata}, 16'h0034);
    chk("B_pixel_kept_we", {15'd0, we_n}, 16'd0);
    wait_done("B", n);
    chk("B_bytes", 16'(n), 16'd8);

    // frame_start while in HIGH after two pixels
    pif.frame_start = 1'b1; pif.pix_valid = 1'b0;
    tick();
    pif.frame_start = 1'b0; pif.pix_valid = 1'b1; pif.pix_data = 15'h1111;
    wait_wrst(n);
    chk("A_wrst_len", 16'(n), 16'd4);
    tick();
    pif.pix_data = 15'h2A55;
    tick();
    tick();
    chk("A_low_byte", {8'd0, fdata}, 16'h0055);
    pif.frame_start = 1'b1;
    #1;
    chk("A_ready_blocked", {15'd0, pif.pix_ready}, 16'd0);
    tick();
    pif.frame_start = 1'b0;
    chk("A_high_dropped", {15'd0, we_n}, 16'd1);
    chk("A_data_held", {8'd0, fdata}, 16'h0055);
    chk("A_err", {15'd0, err}, 16'd1);
    wait_wrst(n);
    chk("A_wrst_len2", 16'(n), 16'd4);
    pif.pix_data = 15'h0102;
    wait_done("A", n);
    chk("A_bytes_after_restart", 16'(n), 16'd8);
    chk("A_err_sticky", {15'd0, err}, 16'd1);

    // asynchronous reset mid-frame
    pif.frame_start = 1'b1;
    tick();
    pif.frame_start = 1'b0;
    wait_wrst(n);
    tick();
    chk("C_pre_we", {15'd0, we_n}, 16'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("C_we_n", {15'd0, we_n}, 16'd1);
    chk("C_wrst_n", {15'd0, wrst_n}, 16'd1);
    chk("C_data", {8'd0, fdata}, 16'd0);
    chk("C_err", {15'd0, err}, 16'd0);
    chk("C_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    pif.pix_valid = 1'b0;
    tick();

`ifdef AL422_WRITER_TEST_PATTERN_EN
    begin
      logic [7:0] got[$];
      int cyc;
      tpif.frame_start = 1'b1;
      tick();
      tpif.frame_start = 1'b0;
      tpif.pix_valid   = 1'b1;
      tpif.pix_data    = 15'h7FFF;
      cyc = 0;
      while (tp_done !== 1'b1 && cyc < 200) begin
        if (tp_we_n === 1'b0) got.push_back(tp_data);
        tick();
        cyc++;
      end
      chk("TP_done_seen", {15'd0, tp_done}, 16'd1);
      chk("TP_byte_count", 16'(got.size()), 16'd32);
      for (int k = 0; k < 32 && k < got.size(); k++) begin
        chk($sformatf("TP_byte%0d", k), {8'd0, got[k]},
            (k >= 16 && (k % 2) == 0) ? 16'h001F : 16'h0000);
      end
      chk("TP_err", {15'd0, tp_err}, 16'd0);
      tick();
      chk("TP_idle_busy", {15'd0, tp_busy}, 16'd0);
      chk("TP_idle_wrst_n", {15'd0, tp_wrst_n}, 16'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/al422_frame_writer.md
Name: al422_frame_writer

Overview:
- Write-side counterpart of the 2-byte-per-pixel RGB555 LED-panel receive path.
- Accepts a pixel stream through a valid/ready handshake and serialises each pixel into two bytes: low byte first, then high byte. The receive side loads the first byte after its phase reset into [7:0] and the second into [15:8].
- Drives the AL422 FIFO write port: active-low write reset, active-low write enable and an 8-bit data bus. The FIFO write clock is in_clk, routed externally.
- Each frame opens with a write-reset pulse so the read side always starts at pixel 0.

Parameters:
- FRAME_PIXELS, 2048, pixels per frame (64x32 panel); legal range 1..65535.
- WRST_CYCLES, 4, number of cycles fifo_wrst_n is held low at frame start; legal range 1..255.

Ports:
- in_clk  input  1  system clock; all logic on posedge.
- in_rst  input  1  asynchronous, active-high reset.
- frame_start  input  1  single-cycle pulse; begins a new frame.
- pix_valid  input  1  pix_data is valid.
- pix_data  input  15  RGB555 pixel: [4:0] red, [9:5] green, [14:10] blue.
- pix_ready  output  1  block accepts pix_data this cycle; combinational.
- fifo_wrst_n  output  1  AL422 write reset, active low; registered.
- fifo_we_n  output  1  AL422 write enable, active low; registered.
- fifo_data  output  8  AL422 write data; registered.
- frame_done  output  1  one-cycle pulse after the last byte of a frame is written.
- frame_err  output  1  sticky flag: a frame was aborted by frame_start mid-frame.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous): state IDLE, fifo_wrst_n=1, fifo_we_n=1, fifo_data=0, frame_done=0, frame_err=0, pixel counter=0, wrst counter=0.
- States: IDLE, WRST, LOW, HIGH, DONE.
- pix_ready = (state==LOW) && !frame_start. A handshake occurs when pix_valid && pix_ready.
- Pixel word: {1'b0, pix_data}. Low byte = word[7:0]; high byte = {1'b0, pix_data[14:8]}.
- IDLE:
  - fifo_we_n=1, fifo_wrst_n=1.
  - frame_start moves to WRST.
- WRST:
  - fifo_wrst_n=0 for exactly WRST_CYCLES cycles, then go to LOW.
  - Pixel counter cleared on entry.
  - A frame_start while in WRST restarts the wrst count; frame_err is not set.
- LOW:
  - On handshake at cycle N: capture the high byte, go to HIGH. At N+1, fifo_data = low byte and fifo_we_n=0.
  - No handshake: fifo_we_n=1 next cycle (bubble). Stay in LOW indefinitely; there is no timeout.
- HIGH:
  - Next cycle (N+2): fifo_data = high byte, fifo_we_n=0. Increment the pixel counter.
  - If the counter reaches FRAME_PIXELS, go to DONE; otherwise go to LOW.
  - Sustained throughput: 1 pixel per 2 cycles, with fifo_we_n continuously low under back-to-back valid.
- DONE:
  - frame_done=1 for one cycle, fifo_we_n=1, then go to IDLE.
  - pix_ready stays 0 until the next frame's WRST completes.
- Mid-frame restart:
  - frame_start in LOW, HIGH or DONE sets frame_err=1 (LOW/HIGH only; DONE counts as frame complete, no error) and drives fifo_we_n=1 next cycle.
  - A pending high byte is dropped. Enter WRST.
  - frame_start wins over a simultaneous pixel handshake: pix_ready is low that cycle.
- frame_err clears only on in_rst.
- fifo_data holds its last value while fifo_we_n=1.
- Pixel counter is 16 bits; it never wraps within a frame because DONE is entered at FRAME_PIXELS.
- in_rst mid-frame: all outputs return to reset values immediately; a partially written FIFO frame is discarded by the next WRST.

Optional Feature:
- Macro: AL422_WRITER_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1, latched at WRST entry for the whole frame, pix_data is ignored and the pixel word is generated internally. The colour bar index is pixel_counter[5:3]: bit0→red=31, bit1→green=31, bit2→blue=31, other components 0.
  - pix_ready still gates timing, so the upstream source can free-run with pix_valid=1.
- Not defined: no test_mode port and no pattern logic; behaviour is exactly as above.

Test Plan:
- Reset, then frame_start, FRAME_PIXELS=4, WRST_CYCLES=4, pix_valid=1 continuously with pixels 0x7FFF, 0x1234, 0x0001, 0x4210:
  - fifo_wrst_n low for exactly 4 cycles.
  - Then bytes FF,7F,34,12,01,00,10,42 with fifo_we_n low for 8 consecutive cycles.
  - frame_done pulses one cycle later; pix_ready=0 afterwards.
- Same frame with pix_valid toggling every other cycle:
  - fifo_we_n shows one-cycle bubbles.
  - Byte order and values unchanged; frame_done after the 8th byte.
- frame_start asserted while in HIGH after 2 pixels:
  - The second high byte is not written.
  - frame_err=1 and stays 1.
  - A new WRST pulse is 4 cycles long; the pixel counter restarts at 0.
- frame_start on the same cycle as pix_valid in LOW:
  - pix_ready=0, pixel not consumed, no fifo_we_n low.
  - frame_err=1; WRST entered.
- in_rst asserted mid-frame:
  - Outputs immediately go to fifo_we_n=1, fifo_wrst_n=1, fifo_data=0, frame_err=0, busy=0.
- With AL422_WRITER_TEST_PATTERN_EN and test_mode=1, FRAME_PIXELS=16:
  - Pixels 0-7 yield bytes 00,00; pixels 8-15 yield 1F,00.
  - pix_data is ignored.
